sparse_matmul_stream: RTL and testbench
=======================================

Name: sparse_matmul_stream

Overview:
Parametrised N×N matrix multiplier with streaming valid/ready load and drain. It replaces the fixed 3×3 combinational-in-one-clock multiply with a sequential single-MAC datapath that has an optional zero-skip mode.
- Operands A then B arrive row-major on one input stream.
- C = A×B is computed one MAC per cycle.
- Results leave row-major on an output stream.
- Sits between the operand block RAM readers and the debug/result consumers.

Parameters:
N, 3, matrix dimension (N ≥ 2).
DATA_W, 8, unsigned operand element width.
ACC_W, 20, accumulator/result width. Elaboration error if ACC_W < 2*DATA_W + clog2(N).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block accepts operand beat.
in_data  in  DATA_W  operand element; beats 0..N*N-1 are A row-major, beats N*N..2*N*N-1 are B row-major.
skip_en  in  1  zero-skip mode; sampled on the LOAD→COMPUTE transition.
out_valid  out  1  result beat valid.
out_ready  in  1  consumer accepts result beat.
out_data  out  ACC_W  C element, row-major.
out_last  out  1  high with the final C element (index N*N-1).
busy  out  1  high in COMPUTE and DRAIN.
mac_count  out  clog2(N*N*N+1)  cycles spent in the last COMPUTE phase; held until the next COMPUTE starts.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state = LOAD; all index counters = 0.
  - in_ready = 1; out_valid = 0; out_last = 0; out_data = 0; busy = 0; mac_count = 0.
  - A/B/C buffers and the nonzero mask need not be cleared.
- FSM states: LOAD, COMPUTE, DRAIN.
- LOAD:
  - in_ready = 1. A beat is accepted when in_valid && in_ready.
  - A beat writes the A or B buffer at a load index. The index increments only on accept; in_valid gaps are allowed.
  - While A beats load, a per-element nonzero bit nzA[i][k] is recorded.
  - On accept of beat 2*N*N-1: next cycle state = COMPUTE, skip_q ← skip_en, mac_count ← 0, load index ← 0.
- COMPUTE:
  - in_ready = 0; one MAC per cycle; iterate i (row), j (col), k.
  - skip_q = 0: each (i,j) takes exactly N cycles, k = 0..N-1.
  - skip_q = 1: k visits only the set bits of nzA[i][*] in ascending order.
    - Each (i,j) takes max(1, popcount(nzA[i][*])) cycles.
    - An all-zero row takes 1 cycle and writes 0.
  - On each (i,j)'s final cycle, the accumulator plus current product is written to C[i][j]. The accumulator clears for the next (i,j); there is no bubble between elements.
  - mac_count increments every COMPUTE cycle.
  - After the final cycle of (N-1,N-1): next state = DRAIN.
- Arithmetic:
  - Unsigned; product width 2*DATA_W, zero-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W, which cannot occur given the parameter check.
- DRAIN:
  - out_valid = 1. out_data = C[drain index]; out_last = (drain index == N*N-1).
  - The index advances only on out_valid && out_ready. out_data and out_last stay stable while out_ready = 0.
  - After accepting the last beat: next state = LOAD, out_valid = 0.
- Latency:
  - First out_valid rises 1 + mac_count cycles after the cycle in which the last B beat was accepted.
  - Example: dense N=3 gives 28 cycles.
- No overlap: new operands are not accepted until DRAIN completes (in_ready = 0 in COMPUTE/DRAIN).
- skip_en changes outside the LOAD→COMPUTE edge have no effect on the running computation.
- Reset mid-operation (any state): immediate return to the reset values above; a partially loaded matrix is discarded.

Decomposition:
- Package matmul_pkg:
  - state enum {LOAD, COMPUTE, DRAIN};
  - localparam helper functions for index widths (clog2(N), clog2(N*N), clog2(N*N*N+1));
  - the ACC_W legality check function.
- Sub-module nz_index_finder (combinational):
  - inputs: an N-bit mask and a start index;
  - outputs: the next set-bit index ≥ start, a found flag, and an is-last-set-bit flag.
  - Used by COMPUTE to select k in skip mode.

Test Plan:
1. Dense, skip_en=0: A=[1..9], B=[9..1] row-major, N=3 → out 30,24,18,84,69,54,138,114,90; out_last only on 90; mac_count=27; first out_valid 28 cycles after last B accept.
2. Identity A, B=[9..1], skip_en=1 → out equals B; mac_count=9. Same with skip_en=0 → identical data, mac_count=27.
3. All-zero A, skip_en=1, arbitrary B → nine zeros; mac_count=9.
4. Max values: all A and B elements 255 → every C element 195075; no wrap at ACC_W=20.
5. Backpressure and gaps: random in_valid gaps during LOAD, out_ready low for 5 cycles mid-DRAIN → no lost or duplicated beats, out_data held stable, in_ready=0 until final result accepted.
6. Reset mid-COMPUTE, then a fresh dense load → out_valid=0 and in_ready=1 right after the rst_n assert; second run yields case-1 results exactly.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and elaboration helpers for the streaming sparse matrix multiplier.
// Index widths are derived here so the top and sub-module agree on sizing.
package matmul_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int elem_w(input int n);
    return idx_w(n * n);
  endfunction

  function automatic int mac_w(input int n);
    return $clog2(n * n * n + 1);
  endfunction

  // Accumulator must hold N full-width products without wrapping.
  function automatic bit acc_w_ok(input int n, input int data_w, input int acc_w);
    return acc_w >= 2 * data_w + $clog2(n);
  endfunction

endpackage

// File: rtl/nz_index_finder.sv
// Finds the first set mask bit at or above start; purely combinational, no latency.
// No flow control: result is valid in the same cycle the mask/start are presented.
module nz_index_finder #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          found,
  output logic          last
);

  logic more;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    more  = 1'b0;
    for (int b = 0; b < N; b++) begin
      if (mask[b] && (b >= int'(start))) begin
        if (!found) begin
          found = 1'b1;
          idx   = IW'(b);
        end else begin
          more = 1'b1;
        end
      end
    end
    last = found && !more;
  end

endmodule

// File: rtl/sparse_matmul_stream.sv
// N x N multiply, one MAC per cycle; first result 1 + mac_count cycles after the last B beat.
// Load stalls nothing (in_ready high in LOAD); results hold stable while out_ready is low.
module sparse_matmul_stream
  import matmul_pkg::*;
#(
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  skip_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [mac_w(N)-1:0]   mac_count
);

  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  generate
    if (!acc_w_ok(N, DATA_W, ACC_W)) begin : g_acc_w_check
      $error("sparse_matmul_stream: ACC_W too narrow for N and DATA_W");
    end
  endgenerate

  state_t state, state_nxt;

  logic [IW-1:0]     ld_r, ld_c;
  logic              ld_b;
  logic [IW-1:0]     ci, cj, ck;
  logic [IW-1:0]     dr_r, dr_c;
  logic              skip_q;
  logic [ACC_W-1:0]  acc;

  logic [DATA_W-1:0] a_mem [N][N];
  logic [DATA_W-1:0] b_mem [N][N];
  logic [ACC_W-1:0]  c_mem [N][N];
  logic [N-1:0]      nz_a  [N];

  logic              in_fire, out_fire, ld_done, dr_done;
  logic [IW-1:0]     nz_idx;
  logic              nz_found, nz_last;
  logic [IW-1:0]     k_sel;
  logic              k_last, elem_done, cmp_done;
  logic [2*DATA_W-1:0] mul;
  logic [ACC_W-1:0]  prod, sum;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign ld_done  = in_fire && ld_b && (ld_r == LAST_IDX) && (ld_c == LAST_IDX);
  assign dr_done  = out_fire && (dr_r == LAST_IDX) && (dr_c == LAST_IDX);

  nz_index_finder #(.N(N), .IW(IW)) u_nz (
    .mask  (nz_a[ci]),
    .start (ck),
    .idx   (nz_idx),
    .found (nz_found),
    .last  (nz_last)
  );

  // In skip mode ck is a search start; an all-zero row still spends one cycle writing 0.
  assign k_sel     = skip_q ? nz_idx : ck;
  assign k_last    = skip_q ? (!nz_found || nz_last) : (ck == LAST_IDX);
  assign mul       = {{DATA_W{1'b0}}, a_mem[ci][k_sel]} * {{DATA_W{1'b0}}, b_mem[k_sel][cj]};
  assign prod      = (!skip_q || nz_found) ? {{(ACC_W-2*DATA_W){1'b0}}, mul} : '0;
  assign sum       = acc + prod;
  assign elem_done = (state == COMPUTE) && k_last;
  assign cmp_done  = elem_done && (ci == LAST_IDX) && (cj == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (ld_done)  state_nxt = COMPUTE;
      COMPUTE: if (cmp_done) state_nxt = DRAIN;
      DRAIN:   if (dr_done)  state_nxt = LOAD;
      default:               state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == DRAIN);
    busy      = (state == COMPUTE) || (state == DRAIN);
    out_data  = out_valid ? c_mem[dr_r][dr_c] : '0;
    out_last  = out_valid && (dr_r == LAST_IDX) && (dr_c == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_r      <= '0;
      ld_c      <= '0;
      ld_b      <= 1'b0;
      ci        <= '0;
      cj        <= '0;
      ck        <= '0;
      dr_r      <= '0;
      dr_c      <= '0;
      skip_q    <= 1'b0;
      acc       <= '0;
      mac_count <= '0;
    end else begin
      if (in_fire) begin
        if (ld_c == LAST_IDX) begin
          ld_c <= '0;
          if (ld_r == LAST_IDX) begin
            ld_r <= '0;
            ld_b <= ~ld_b;
          end else begin
            ld_r <= ld_r + 1'b1;
          end
        end else begin
          ld_c <= ld_c + 1'b1;
        end
      end

      if (ld_done) begin
        skip_q    <= skip_en;
        mac_count <= '0;
        acc       <= '0;
        ci        <= '0;
        cj        <= '0;
        ck        <= '0;
      end

      if (state == COMPUTE) begin
        mac_count <= mac_count + 1'b1;
        if (k_last) begin
          acc <= '0;
          ck  <= '0;
          if (cj == LAST_IDX) begin
            cj <= '0;
            ci <= (ci == LAST_IDX) ? '0 : ci + 1'b1;
          end else begin
            cj <= cj + 1'b1;
          end
        end else begin
          acc <= sum;
          ck  <= k_sel + 1'b1;
        end
      end

      if (out_fire) begin
        if (dr_c == LAST_IDX) begin
          dr_c <= '0;
          dr_r <= (dr_r == LAST_IDX) ? '0 : dr_r + 1'b1;
        end else begin
          dr_c <= dr_c + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (!ld_b) begin
        a_mem[ld_r][ld_c] <= in_data;
        nz_a[ld_r][ld_c]  <= |in_data;
      end else begin
        b_mem[ld_r][ld_c] <= in_data;
      end
    end
    if (elem_done) c_mem[ci][cj] <= sum;
  end

endmodule

// File: tb/tb_sparse_matmul_stream.sv
// Directed bench for sparse_matmul_stream with a loop-based reference model and
// a per-cycle output compare process.
module tb_sparse_matmul_stream;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 20;
  localparam int MW = $clog2(N*N*N + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          skip_en;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic [MW-1:0] mac_count;

  sparse_matmul_stream #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .skip_en   (skip_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .mac_count (mac_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int exp_c [9];
  int got   [9];
  int exp_mac;
  int ptr = 0;

  int a_seq  [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int b_seq  [9] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
  int a_id   [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  int a_zero [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
  int a_sp   [9] = '{0, 2, 0, 3, 0, 4, 0, 0, 0};
  int m_max  [9] = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
  int c_dense[9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

  task automatic check(input string name, input longint act, input longint expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: plain matrix product; skip mode costs max(1, nonzeros in A row) per element.
  function automatic void model(input int a[9], input int b[9], input bit skip);
    int nz;
    exp_mac = 0;
    for (int i = 0; i < N; i++) begin
      nz = 0;
      for (int k = 0; k < N; k++) if (a[i*N+k] != 0) nz++;
      exp_mac += N * (skip ? ((nz == 0) ? 1 : nz) : N);
      for (int j = 0; j < N; j++) begin
        exp_c[i*N+j] = 0;
        for (int k = 0; k < N; k++) exp_c[i*N+j] += a[i*N+k] * b[k*N+j];
      end
    end
  endfunction

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (busy) check("in_ready_while_busy", in_ready, 0);
      if (out_valid) begin
        if (ptr >= N*N) begin
          check("extra_beat", ptr, N*N-1);
        end else begin
          check("out_data", out_data, exp_c[ptr]);
          check("out_last", out_last, ptr == N*N-1);
        end
        if (out_ready) ptr++;
      end else begin
        ptr = 0;
      end
    end
  endtask

  task automatic load_ops(input int a[9], input int b[9], input bit skip, input bit gaps);
    skip_en = skip;
    for (int beat = 0; beat < 2*N*N; beat++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = DW'((beat < N*N) ? a[beat] : b[beat-N*N]);
      check("in_ready_load", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    skip_en  = !skip;
  endtask

  task automatic run(input int a[9], input int b[9], input bit skip, input bit gaps,
                     input bit stall);
    int acc_cyc;
    int n;
    int cnt;
    int st;
    model(a, b, skip);
    out_ready = 1'b0;
    load_ops(a, b, skip, gaps);
    acc_cyc = cyc;
    n = 0;
    while (!out_valid && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      check("timeout_compute", 0, 1);
      return;
    end
    // acc_cyc is sampled just after the accepting edge, so add the accept cycle itself.
    check("first_valid_latency", cyc - acc_cyc + 1, 1 + exp_mac);
    check("mac_count", mac_count, exp_mac);
    cnt = 0;
    n = 0;
    st = stall ? 5 : 0;
    while (cnt < N*N && n < 200) begin
      if (cnt == 4 && st > 0) begin
        out_ready = 1'b0;
        st--;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        got[cnt] = int'(out_data);
        cnt++;
      end
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    check("drain_beats", cnt, N*N);
    check("out_valid_after_drain", out_valid, 0);
    check("in_ready_after_drain", in_ready, 1);
    check("busy_after_drain", busy, 0);
    check("mac_count_held", mac_count, exp_mac);
    for (int i = 0; i < N*N; i++) check("captured", got[i], exp_c[i]);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    skip_en   = 1'b0;
    out_ready = 1'b0;
    fork
      compare_loop();
    join_none
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_mac_count", mac_count, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: dense
    run(a_seq, b_seq, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N*N; i++) check("dense_literal", got[i], c_dense[i]);
    check("dense_mac_literal", mac_count, 27);

    // 2: identity, skip then dense
    run(a_id, b_seq, 1'b1, 1'b0, 1'b0);
    check("ident_skip_mac", mac_count, 9);
    check("ident_skip_c0", got[0], 9);
    check("ident_skip_c8", got[8], 1);
    run(a_id, b_seq, 1'b0, 1'b0, 1'b0);
    check("ident_dense_mac", mac_count, 27);
    check("ident_dense_c4", got[4], 5);

    // 3: all-zero A with skip
    run(a_zero, b_seq, 1'b1, 1'b0, 1'b0);
    check("zero_skip_mac", mac_count, 9);
    check("zero_skip_c3", got[3], 0);

    // sparse A with skip: rows carry 1, 2 and 0 nonzeros
    run(a_sp, b_seq, 1'b1, 1'b0, 1'b0);
    check("sparse_skip_mac", mac_count, 12);
    check("sparse_c3", got[3], 39);

    // 4: max values
    run(m_max, m_max, 1'b0, 1'b0, 1'b0);
    check("max_c0", got[0], 195075);
    check("max_c8", got[8], 195075);

    // 5: input gaps and output stall
    run(a_seq, b_seq, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < N*N; i++) check("stall_literal", got[i], c_dense[i]);

    // 6: reset mid-COMPUTE then a fresh dense run
    load_ops(a_seq, b_seq, 1'b0, 1'b0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("mid_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mac_count", mac_count, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run(a_seq, b_seq, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N*N; i++) check("post_rst_literal", got[i], c_dense[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
